// File: rtl/control_unit_pkg.sv
// control_unit_pkg: opcodes, ALU function codes, sequencer states, instruction classes
// and the control-strobe bundle shared by the sequencer and its opcode decoder.
package control_unit_pkg;

  localparam int IR_W     = 32;
  localparam int OPC_W    = 5;
  localparam int ALU_OP_W = 5;

  localparam logic [OPC_W-1:0] OPC_LD   = 5'b00000;
  localparam logic [OPC_W-1:0] OPC_LDI  = 5'b00001;
  localparam logic [OPC_W-1:0] OPC_ST   = 5'b00010;
  localparam logic [OPC_W-1:0] OPC_ADD  = 5'b00011;
  localparam logic [OPC_W-1:0] OPC_SUB  = 5'b00100;
  localparam logic [OPC_W-1:0] OPC_AND  = 5'b00101;
  localparam logic [OPC_W-1:0] OPC_OR   = 5'b00110;
  localparam logic [OPC_W-1:0] OPC_NEG  = 5'b10001;
  localparam logic [OPC_W-1:0] OPC_NOT  = 5'b10010;
  localparam logic [OPC_W-1:0] OPC_NOP  = 5'b11010;
  localparam logic [OPC_W-1:0] OPC_HALT = 5'b11011;

  // ALU codes reuse the opcode of the matching instruction; NONE is driven whenever
  // the ALU result is not being captured (the T0 PC increment is carried by IncPC).
  localparam logic [ALU_OP_W-1:0] ALU_NONE = 5'b00000;
  localparam logic [ALU_OP_W-1:0] ALU_ADD  = 5'b00011;
  localparam logic [ALU_OP_W-1:0] ALU_SUB  = 5'b00100;
  localparam logic [ALU_OP_W-1:0] ALU_AND  = 5'b00101;
  localparam logic [ALU_OP_W-1:0] ALU_OR   = 5'b00110;
  localparam logic [ALU_OP_W-1:0] ALU_NEG  = 5'b10001;
  localparam logic [ALU_OP_W-1:0] ALU_NOT  = 5'b10010;

  typedef enum logic [3:0] {
    S_RST  = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6,
    S_T6   = 4'd7,
    S_T7   = 4'd8,
    S_HALT = 4'd9
  } state_e;

  typedef enum logic [2:0] {
    CLS_ALU3 = 3'd0,
    CLS_ALU2 = 3'd1,
    CLS_LDI  = 3'd2,
    CLS_LD   = 3'd3,
    CLS_ST   = 3'd4,
    CLS_NOP  = 3'd5,
    CLS_HALT = 3'd6
  } iclass_e;

  typedef struct packed {
    logic pc_out;
    logic zlow_out;
    logic mdr_out;
    logic ba_out;
    logic c_out;
    logic pc_in;
    logic mar_in;
    logic mdr_in;
    logic ir_in;
    logic y_in;
    logic z_in;
    logic gra;
    logic grb;
    logic grc;
    logic r_in;
    logic r_out;
    logic inc_pc;
    logic read;
    logic write;
  } ctrl_t;

endpackage

// File: rtl/control_unit_instr_class_decode.sv
// control_unit_instr_class_decode: maps the IR opcode field to an execute class and
// the ALU function used by that class. Undefined opcodes decode as NOP.
module control_unit_instr_class_decode
  import control_unit_pkg::*;
(
  input  logic [OPC_W-1:0]    opcode_i,
  output iclass_e             iclass_o,
  output logic [ALU_OP_W-1:0] alu_op_o
);

  always_comb begin
    iclass_o = CLS_NOP;
    alu_op_o = ALU_NONE;
    case (opcode_i)
      OPC_LD:   begin iclass_o = CLS_LD;   alu_op_o = ALU_ADD; end
      OPC_LDI:  begin iclass_o = CLS_LDI;  alu_op_o = ALU_ADD; end
      OPC_ST:   begin iclass_o = CLS_ST;   alu_op_o = ALU_ADD; end
      OPC_ADD:  begin iclass_o = CLS_ALU3; alu_op_o = ALU_ADD; end
      OPC_SUB:  begin iclass_o = CLS_ALU3; alu_op_o = ALU_SUB; end
      OPC_AND:  begin iclass_o = CLS_ALU3; alu_op_o = ALU_AND; end
      OPC_OR:   begin iclass_o = CLS_ALU3; alu_op_o = ALU_OR;  end
      OPC_NEG:  begin iclass_o = CLS_ALU2; alu_op_o = ALU_NEG; end
      OPC_NOT:  begin iclass_o = CLS_ALU2; alu_op_o = ALU_NOT; end
      OPC_HALT: iclass_o = CLS_HALT;
      default:  iclass_o = CLS_NOP;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// control_unit: hardwired Moore sequencer for the single-bus datapath (fetch T0-T2, execute T3-T7).
// Build option MEM_WAIT_EN: T1, LD-T6 and ST-T7 stall until Mem_ready_i is high.
module control_unit
  import control_unit_pkg::*;
(
  input  logic                Clock_i,
  input  logic                Reset_i,
  input  logic [IR_W-1:0]     IR_i,
  input  logic                Mem_ready_i,
  output logic                PCout_o,
  output logic                Zlowout_o,
  output logic                MDRout_o,
  output logic                BAout_o,
  output logic                Cout_o,
  output logic                PCin_o,
  output logic                MARin_o,
  output logic                MDRin_o,
  output logic                IRin_o,
  output logic                Yin_o,
  output logic                Zin_o,
  output logic                Gra_o,
  output logic                Grb_o,
  output logic                Grc_o,
  output logic                Rin_o,
  output logic                Rout_o,
  output logic                IncPC_o,
  output logic                Read_o,
  output logic                Write_o,
  output logic [ALU_OP_W-1:0] ALU_op_o,
  output logic                Run_o
);

  state_e              state_q, state_d;
  iclass_e             iclass;
  logic [ALU_OP_W-1:0] dec_alu_op;
  logic                mem_done;
  ctrl_t               ctrl;
  logic [ALU_OP_W-1:0] alu_op;
  logic                run;
  logic                unused_ir;

  assign unused_ir = ^IR_i[IR_W-OPC_W-1:0];

  control_unit_instr_class_decode u_decode (
    .opcode_i (IR_i[IR_W-1 -: OPC_W]),
    .iclass_o (iclass),
    .alu_op_o (dec_alu_op)
  );

`ifdef MEM_WAIT_EN
  assign mem_done = Mem_ready_i;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = Mem_ready_i;
  assign mem_done         = 1'b1;
`endif

  always_ff @(posedge Clock_i) begin
    if (Reset_i) state_q <= S_RST;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ctrl    = '0;
    alu_op  = ALU_NONE;
    run     = 1'b1;
    case (state_q)
      S_RST: begin
        run     = 1'b0;
        state_d = S_T0;
      end
      S_T0: begin
        ctrl.pc_out = 1'b1; ctrl.mar_in = 1'b1; ctrl.inc_pc = 1'b1; ctrl.z_in = 1'b1;
        state_d = S_T1;
      end
      S_T1: begin
        ctrl.zlow_out = 1'b1; ctrl.pc_in = 1'b1; ctrl.read = 1'b1; ctrl.mdr_in = 1'b1;
        if (mem_done) state_d = S_T2;
      end
      S_T2: begin
        ctrl.mdr_out = 1'b1; ctrl.ir_in = 1'b1;
        case (iclass)
          CLS_NOP:  state_d = S_T0;
          CLS_HALT: state_d = S_HALT;
          default:  state_d = S_T3;
        endcase
      end
      S_T3: begin
        state_d = S_T4;
        case (iclass)
          CLS_ALU3: begin ctrl.grb = 1'b1; ctrl.r_out = 1'b1; ctrl.y_in = 1'b1; end
          CLS_ALU2: begin
            ctrl.grb = 1'b1; ctrl.r_out = 1'b1; ctrl.z_in = 1'b1;
            alu_op   = dec_alu_op;
          end
          CLS_LDI, CLS_LD, CLS_ST: begin ctrl.grb = 1'b1; ctrl.ba_out = 1'b1; ctrl.y_in = 1'b1; end
          default: state_d = S_T0;
        endcase
      end
      S_T4: begin
        state_d = S_T5;
        case (iclass)
          CLS_ALU3: begin
            ctrl.grc = 1'b1; ctrl.r_out = 1'b1; ctrl.z_in = 1'b1;
            alu_op   = dec_alu_op;
          end
          CLS_ALU2: begin
            ctrl.zlow_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1;
            state_d = S_T0;
          end
          CLS_LDI, CLS_LD, CLS_ST: begin
            ctrl.c_out = 1'b1; ctrl.z_in = 1'b1;
            alu_op     = dec_alu_op;
          end
          default: state_d = S_T0;
        endcase
      end
      S_T5: begin
        state_d = S_T0;
        case (iclass)
          CLS_ALU3, CLS_LDI: begin ctrl.zlow_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1; end
          CLS_LD, CLS_ST: begin
            ctrl.zlow_out = 1'b1; ctrl.mar_in = 1'b1;
            state_d = S_T6;
          end
          default: state_d = S_T0;
        endcase
      end
      // ST-T6 deliberately leaves Read low so MDR takes the bus value, not memory.
      S_T6: begin
        state_d = S_T0;
        case (iclass)
          CLS_LD: begin
            ctrl.read = 1'b1; ctrl.mdr_in = 1'b1;
            state_d   = mem_done ? S_T7 : S_T6;
          end
          CLS_ST: begin
            ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.mdr_in = 1'b1;
            state_d  = S_T7;
          end
          default: state_d = S_T0;
        endcase
      end
      S_T7: begin
        state_d = S_T0;
        case (iclass)
          CLS_LD: begin ctrl.mdr_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1; end
          CLS_ST: begin
            ctrl.write = 1'b1;
            state_d    = mem_done ? S_T0 : S_T7;
          end
          default: state_d = S_T0;
        endcase
      end
      S_HALT: run = 1'b0;
      default: begin
        run     = 1'b0;
        state_d = S_RST;
      end
    endcase
  end

  assign PCout_o   = ctrl.pc_out;
  assign Zlowout_o = ctrl.zlow_out;
  assign MDRout_o  = ctrl.mdr_out;
  assign BAout_o   = ctrl.ba_out;
  assign Cout_o    = ctrl.c_out;
  assign PCin_o    = ctrl.pc_in;
  assign MARin_o   = ctrl.mar_in;
  assign MDRin_o   = ctrl.mdr_in;
  assign IRin_o    = ctrl.ir_in;
  assign Yin_o     = ctrl.y_in;
  assign Zin_o     = ctrl.z_in;
  assign Gra_o     = ctrl.gra;
  assign Grb_o     = ctrl.grb;
  assign Grc_o     = ctrl.grc;
  assign Rin_o     = ctrl.r_in;
  assign Rout_o    = ctrl.r_out;
  assign IncPC_o   = ctrl.inc_pc;
  assign Read_o    = ctrl.read;
  assign Write_o   = ctrl.write;
  assign ALU_op_o  = alu_op;
  assign Run_o     = run;

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed instruction sequences; the stimulus queues the expected strobe
// set for every cycle it drives and a negedge monitor pops and compares.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_ready;
  logic [31:0] ir;

  logic PCout, Zlowout, MDRout, BAout, Cout, PCin, MARin, MDRin, IRin, Yin, Zin;
  logic Gra, Grb, Grc, Rin, Rout, IncPC, Read, Write, Run;
  logic [4:0] alu_op;

  always #5 clk = ~clk;

  control_unit dut (
    .Clock_i(clk), .Reset_i(reset), .IR_i(ir), .Mem_ready_i(mem_ready),
    .PCout_o(PCout), .Zlowout_o(Zlowout), .MDRout_o(MDRout), .BAout_o(BAout), .Cout_o(Cout),
    .PCin_o(PCin), .MARin_o(MARin), .MDRin_o(MDRin), .IRin_o(IRin), .Yin_o(Yin), .Zin_o(Zin),
    .Gra_o(Gra), .Grb_o(Grb), .Grc_o(Grc), .Rin_o(Rin), .Rout_o(Rout),
    .IncPC_o(IncPC), .Read_o(Read), .Write_o(Write), .ALU_op_o(alu_op), .Run_o(Run)
  );

  localparam logic [18:0] PCOUT   = 19'd1 << 18;
  localparam logic [18:0] ZLOWOUT = 19'd1 << 17;
  localparam logic [18:0] MDROUT  = 19'd1 << 16;
  localparam logic [18:0] BAOUT   = 19'd1 << 15;
  localparam logic [18:0] COUT    = 19'd1 << 14;
  localparam logic [18:0] PCIN    = 19'd1 << 13;
  localparam logic [18:0] MARIN   = 19'd1 << 12;
  localparam logic [18:0] MDRIN   = 19'd1 << 11;
  localparam logic [18:0] IRIN    = 19'd1 << 10;
  localparam logic [18:0] YIN     = 19'd1 << 9;
  localparam logic [18:0] ZIN     = 19'd1 << 8;
  localparam logic [18:0] GRA     = 19'd1 << 7;
  localparam logic [18:0] GRB     = 19'd1 << 6;
  localparam logic [18:0] GRC     = 19'd1 << 5;
  localparam logic [18:0] RIN     = 19'd1 << 4;
  localparam logic [18:0] ROUT    = 19'd1 << 3;
  localparam logic [18:0] INCPC   = 19'd1 << 2;
  localparam logic [18:0] READ    = 19'd1 << 1;
  localparam logic [18:0] WRITE   = 19'd1;

  localparam logic [4:0] A_NONE = 5'b00000;
  localparam logic [4:0] A_ADD  = 5'b00011;
  localparam logic [4:0] A_SUB  = 5'b00100;
  localparam logic [4:0] A_AND  = 5'b00101;
  localparam logic [4:0] A_OR   = 5'b00110;
  localparam logic [4:0] A_NEG  = 5'b10001;
  localparam logic [4:0] A_NOT  = 5'b10010;

  localparam logic [31:0] I_AND   = 32'h2891_8000;
  localparam logic [31:0] I_NEG   = 32'h8808_0000;
  localparam logic [31:0] I_LD    = 32'h0100_0055;
  localparam logic [31:0] I_LDI   = 32'h0880_0007;
  localparam logic [31:0] I_ST    = 32'h1080_0010;
  localparam logic [31:0] I_ADD   = 32'h1800_0000;
  localparam logic [31:0] I_SUB   = 32'h2000_0000;
  localparam logic [31:0] I_OR    = 32'h3000_0000;
  localparam logic [31:0] I_NOT   = 32'h9000_0000;
  localparam logic [31:0] I_NOP   = 32'hD000_0000;
  localparam logic [31:0] I_HALT  = 32'hD800_0000;
  localparam logic [31:0] I_UNDEF = 32'hF800_0000;

  typedef struct {
    string      name;
    logic       run;
    logic [4:0] alu;
    logic [18:0] strb;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  logic [18:0] act_strb;
  assign act_strb = {PCout, Zlowout, MDRout, BAout, Cout, PCin, MARin, MDRin, IRin, Yin, Zin,
                     Gra, Grb, Grc, Rin, Rout, IncPC, Read, Write};

  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      n_cmp++;
      if (Run !== e.run || alu_op !== e.alu || act_strb !== e.strb) begin
        n_fail++;
        $display("FAIL %s: got run=%b alu=%05b strb=%019b, expected run=%b alu=%05b strb=%019b",
                 e.name, Run, alu_op, act_strb, e.run, e.alu, e.strb);
      end
    end
  end

  task automatic step(input string name, input logic run, input logic [4:0] alu,
                      input logic [18:0] strb);
    exp_t e;
    @(posedge clk);
    #1;
    e.name = name; e.run = run; e.alu = alu; e.strb = strb;
    sb_q.push_back(e);
  endtask

  task automatic ex(input string name, input logic [4:0] alu, input logic [18:0] strb);
    step(name, 1'b1, alu, strb);
  endtask

  task automatic off(input string name);
    step(name, 1'b0, A_NONE, 19'd0);
  endtask

  // hold > 0 drops Mem_ready for that many T1 cycles.
  task automatic fetch(input string pfx, input logic [31:0] val, input int hold);
    ex({pfx, "_t0"}, A_NONE, PCOUT | MARIN | INCPC | ZIN);
    ir = val;
    if (hold > 0) mem_ready = 1'b0;
`ifdef MEM_WAIT_EN
    for (int i = 0; i < hold; i++) ex({pfx, "_t1wait"}, A_NONE, ZLOWOUT | PCIN | READ | MDRIN);
    mem_ready = 1'b1;
    ex({pfx, "_t1"}, A_NONE, ZLOWOUT | PCIN | READ | MDRIN);
`else
    ex({pfx, "_t1"}, A_NONE, ZLOWOUT | PCIN | READ | MDRIN);
    mem_ready = 1'b1;
`endif
    ex({pfx, "_t2"}, A_NONE, MDROUT | IRIN);
  endtask

  task automatic alu3(input string pfx, input logic [31:0] val, input logic [4:0] op, input int hold);
    fetch(pfx, val, hold);
    ex({pfx, "_t3"}, A_NONE, GRB | ROUT | YIN);
    ex({pfx, "_t4"}, op, GRC | ROUT | ZIN);
    ex({pfx, "_t5"}, A_NONE, ZLOWOUT | GRA | RIN);
  endtask

  task automatic alu2(input string pfx, input logic [31:0] val, input logic [4:0] op);
    fetch(pfx, val, 0);
    ex({pfx, "_t3"}, op, GRB | ROUT | ZIN);
    ex({pfx, "_t4"}, A_NONE, ZLOWOUT | GRA | RIN);
  endtask

  task automatic addr_calc(input string pfx, input logic [31:0] val);
    fetch(pfx, val, 0);
    ex({pfx, "_t3"}, A_NONE, GRB | BAOUT | YIN);
    ex({pfx, "_t4"}, A_ADD, COUT | ZIN);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    mem_ready = 1'b1;
    ir        = I_AND;
    off("rst_a");
    off("rst_b");
    reset = 1'b0;

    alu3("and", I_AND, A_AND, 0);
    alu2("neg", I_NEG, A_NEG);

    addr_calc("ld", I_LD);
    ex("ld_t5", A_NONE, ZLOWOUT | MARIN);
    ex("ld_t6", A_NONE, READ | MDRIN);
    ex("ld_t7", A_NONE, MDROUT | GRA | RIN);

    addr_calc("ldi", I_LDI);
    ex("ldi_t5", A_NONE, ZLOWOUT | GRA | RIN);

    addr_calc("st", I_ST);
    ex("st_t5", A_NONE, ZLOWOUT | MARIN);
    ex("st_t6", A_NONE, GRA | ROUT | MDRIN);
    ex("st_t7", A_NONE, WRITE);

    alu3("sub_memwait", I_SUB, A_SUB, 3);
    alu3("or", I_OR, A_OR, 0);
    alu2("not", I_NOT, A_NOT);
    fetch("nop", I_NOP, 0);
    fetch("undef", I_UNDEF, 0);

    addr_calc("ldrst", I_LD);
    ex("ldrst_t5", A_NONE, ZLOWOUT | MARIN);
    ex("ldrst_t6", A_NONE, READ | MDRIN);
    reset = 1'b1;
    off("ldrst_abort");
    reset = 1'b0;

    alu3("add", I_ADD, A_ADD, 0);

    fetch("halt", I_HALT, 0);
    for (int i = 0; i < 20; i++) off("halt_idle");
    reset = 1'b1;
    off("halt_rst");
    reset = 1'b0;

    fetch("undef2", I_UNDEF, 0);
    ex("final_t0", A_NONE, PCOUT | MARIN | INCPC | ZIN);

    for (int i = 0; i < 5 && sb_q.size() > 0; i++) @(negedge clk);
    #1;
    if (sb_q.size() > 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain: %0d expected entries left, required 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
